// File: rtl/arm_mem_pkg.sv
// Shared definitions for the ARM memory stage: FSM state encoding,
// SRAM halfword width and the default number of wait cycles per phase.
package arm_mem_pkg;

  localparam int HALF_W            = 16;
  localparam int DEFAULT_SRAM_WAIT = 2;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    FIN
  } mem_state_t;

  // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// External 16-bit SRAM bus seen by the memory stage. The master side is the
// memory stage; the slave side is the SRAM (or the top-level tristate wrapper).
interface mem_stage_if #(
  parameter int SRAM_AW = 18
);
  import arm_mem_pkg::*;

  logic [SRAM_AW-1:0] sram_addr;
  logic               sram_we_n;
  logic [HALF_W-1:0]  sram_dq_out;
  logic               sram_dq_oe;
  logic [HALF_W-1:0]  sram_dq_in;

  modport master (
    output sram_addr,
    output sram_we_n,
    output sram_dq_out,
    output sram_dq_oe,
    input  sram_dq_in
  );

  modport slave (
    input  sram_addr,
    input  sram_we_n,
    input  sram_dq_out,
    input  sram_dq_oe,
    output sram_dq_in
  );

endinterface

// File: rtl/mem_sram_phase.sv
// Per-phase SRAM timing: counts the wait cycles of one halfword phase,
// flags the last cycle back to the FSM and generates the write strobe and
// data-bus drive enable while a phase is active.
module mem_sram_phase
  import arm_mem_pkg::*;
#(
  parameter int SRAM_WAIT = DEFAULT_SRAM_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic write,
  output logic phase_done,
  output logic capture,
  output logic we_n,
  output logic oe
);

  localparam int             CW   = cnt_width(SRAM_WAIT);
  localparam logic [CW-1:0]  LAST = CW'(SRAM_WAIT - 1);

  logic [CW-1:0] count;

  // Wait counter restarts at zero on every new phase and whenever idle.
  always_ff @(posedge clk) begin
    if (rst || !active || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Strobes: writes hold we_n low for the whole phase, reads sample on the last count.
  always_comb begin
    phase_done = active && (count == LAST);
    capture    = phase_done && !write;
    we_n       = !(active && write);
    oe         = active && write;
  end

endmodule

// File: rtl/mem_stage.sv
// ARM pipeline memory stage. Performs 32-bit LDR/STR accesses to a 16-bit
// SRAM as a low then a high halfword phase, freezing upstream stages while
// an access is in flight, and drives the MEM/WB pipeline register.
// Optional build macro MEM_READ_BYPASS_EN adds a one-entry read buffer that
// lets a load to the most recently accessed word complete without stalling.
module mem_stage
  import arm_mem_pkg::*;
#(
  parameter int BIT_NUMBER = 32,
  parameter int SRAM_AW    = 18,
  parameter int SRAM_WAIT  = DEFAULT_SRAM_WAIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic [BIT_NUMBER-1:0] alu_result_in,
  input  logic [BIT_NUMBER-1:0] val_rm_in,
  input  logic [3:0]            dest_in,
  output logic                  ready,
  output logic                  wb_en,
  output logic                  mem_r_en,
  output logic [BIT_NUMBER-1:0] alu_result,
  output logic [BIT_NUMBER-1:0] mem_data,
  output logic [3:0]            dest,
  mem_stage_if.master           sram
);

  localparam int IW = SRAM_AW - 1;

  mem_state_t            state, state_next;
  logic                  request;
  logic                  start;
  logic [IW-1:0]         idx_in;
  logic [IW-1:0]         acc_idx;
  logic                  acc_store;
  logic [BIT_NUMBER-1:0] acc_wdata;
  logic [BIT_NUMBER-1:0] rdata;
  logic                  phase_active;
  logic                  phase_done;
  logic                  capture;
  logic                  we_n;
  logic                  oe;
  logic                  bypass_hit;
  logic [BIT_NUMBER-1:0] bypass_data;

  assign request = mem_r_en_in | mem_w_en_in;
  assign idx_in  = alu_result_in[SRAM_AW:2];

`ifdef MEM_READ_BYPASS_EN
  logic                  buf_valid;
  logic [IW-1:0]         buf_idx;
  logic [BIT_NUMBER-1:0] buf_data;

  assign bypass_hit  = (state == IDLE) && buf_valid && mem_r_en_in && !mem_w_en_in
                       && (buf_idx == idx_in);
  assign bypass_data = buf_data;

  // Read buffer mirrors the word touched by the last completed access.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_idx   <= '0;
      buf_data  <= '0;
    end else if (state == FIN) begin
      buf_valid <= 1'b1;
      buf_idx   <= acc_idx;
      buf_data  <= acc_store ? acc_wdata : rdata;
    end
  end
`else
  assign bypass_hit  = 1'b0;
  assign bypass_data = '0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and freeze: the stage is ready only when nothing is pending.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (request && !bypass_hit) begin
          start      = 1'b1;
          state_next = LO;
        end else begin
          ready = 1'b1;
        end
      end
      LO: begin
        if (phase_done) state_next = HI;
      end
      HI: begin
        if (phase_done) state_next = FIN;
      end
      FIN: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch address, direction and store data at the start of an access.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_idx   <= '0;
      acc_store <= 1'b0;
      acc_wdata <= '0;
    end else if (start) begin
      acc_idx   <= idx_in;
      acc_store <= mem_w_en_in;
      acc_wdata <= val_rm_in;
    end
  end

  // Assemble load data one halfword per phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (capture) begin
      if (state == LO) begin
        rdata[HALF_W-1:0] <= sram.sram_dq_in;
      end else begin
        rdata[BIT_NUMBER-1:HALF_W] <= sram.sram_dq_in;
      end
    end
  end

  assign phase_active = (state == LO) || (state == HI);

  mem_sram_phase #(
    .SRAM_WAIT (SRAM_WAIT)
  ) u_phase (
    .clk        (clk),
    .rst        (rst),
    .active     (phase_active),
    .write      (acc_store),
    .phase_done (phase_done),
    .capture    (capture),
    .we_n       (we_n),
    .oe         (oe)
  );

  assign sram.sram_we_n   = we_n;
  assign sram.sram_dq_oe  = oe;
  assign sram.sram_addr   = phase_active ? {acc_idx, (state == HI)} : '0;
  assign sram.sram_dq_out = oe ? ((state == HI) ? acc_wdata[BIT_NUMBER-1:HALF_W]
                                                : acc_wdata[HALF_W-1:0])
                               : '0;

  // MEM/WB register: load on completion, otherwise hold with a bubbled wb_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en      <= 1'b0;
      mem_r_en   <= 1'b0;
      alu_result <= '0;
      mem_data   <= '0;
      dest       <= '0;
    end else if (state == IDLE && ready) begin
      wb_en      <= wb_en_in;
      mem_r_en   <= bypass_hit;
      alu_result <= alu_result_in;
      mem_data   <= bypass_hit ? bypass_data : '0;
      dest       <= dest_in;
    end else if (state == FIN) begin
      wb_en      <= wb_en_in;
      mem_r_en   <= !acc_store;
      alu_result <= alu_result_in;
      mem_data   <= acc_store ? '0 : rdata;
      dest       <= dest_in;
    end else begin
      wb_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: randomized LDR/STR/ALU traffic against
// a word-level memory model, with a scoreboard queue drained by a monitor
// each time the MEM/WB register updates. Honors MEM_READ_BYPASS_EN.
module tb_mem_stage;
  import arm_mem_pkg::*;

  localparam int BN   = 32;
  localparam int AW   = 18;
  localparam int WAIT = 2;
  localparam int FULL_STALL = 2 * WAIT + 1;

  typedef struct packed {
    logic        wb_en;
    logic        mem_r_en;
    logic [31:0] alu;
    logic [31:0] data;
    logic [3:0]  dest;
  } mw_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [BN-1:0] alu_result_in, val_rm_in;
  logic [3:0]    dest_in;
  logic          ready, wb_en, mem_r_en;
  logic [BN-1:0] alu_result, mem_data;
  logic [3:0]    dest;

  mem_stage_if #(.SRAM_AW(AW)) sram ();

  mem_stage #(
    .BIT_NUMBER (BN),
    .SRAM_AW    (AW),
    .SRAM_WAIT  (WAIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_en_in      (wb_en_in),
    .mem_r_en_in   (mem_r_en_in),
    .mem_w_en_in   (mem_w_en_in),
    .alu_result_in (alu_result_in),
    .val_rm_in     (val_rm_in),
    .dest_in       (dest_in),
    .ready         (ready),
    .wb_en         (wb_en),
    .mem_r_en      (mem_r_en),
    .alu_result    (alu_result),
    .mem_data      (mem_data),
    .dest          (dest),
    .sram          (sram)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  mw_t         exp_q[$];
  bit          mon_en = 1'b0;

  logic [15:0] sram_mem [256];
  int          write_count = 0;

  logic [31:0] ref_mem [64];
  bit          bvalid;
  int          bidx;

  assign sram.sram_dq_in = sram_mem[sram.sram_addr[7:0]];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // SRAM behavioural model: a write cycle stores the driven halfword.
  initial begin
    for (int i = 0; i < 256; i++) sram_mem[i] = 16'h0;
    forever begin
      @(negedge clk);
      if (!sram.sram_we_n) begin
        sram_mem[sram.sram_addr[7:0]] = sram.sram_dq_out;
        write_count++;
      end
    end
  end

  // Monitor: after each edge where the stage was ready, MEM/WB must match the
  // next expected entry; during a freeze wb_en must be a bubble.
  initial begin
    logic r_s, rst_s;
    mw_t  e;
    forever begin
      @(negedge clk);
      r_s   = ready;
      rst_s = rst;
      @(posedge clk);
      #1;
      if (mon_en && !rst_s) begin
        if (r_s) begin
          if (exp_q.size() == 0) begin
            checkOutput("queue_underflow", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("wb_en",      {31'd0, wb_en},    {31'd0, e.wb_en});
            checkOutput("mem_r_en",   {31'd0, mem_r_en}, {31'd0, e.mem_r_en});
            checkOutput("alu_result", alu_result,        e.alu);
            checkOutput("mem_data",   mem_data,          e.data);
            checkOutput("dest",       {28'd0, dest},     {28'd0, e.dest});
          end
        end else begin
          checkOutput("bubble_wb_en", {31'd0, wb_en}, 32'd0);
        end
      end
    end
  end

  // Issue one instruction (entered at posedge+2), hold it until accepted.
  task automatic applyStimulus(input logic wb, input logic r, input logic w,
                               input logic [31:0] alu, input logic [31:0] rm,
                               input logic [3:0] d);
    int  idx;
    int  exp_stall;
    int  stalls;
    bit  hit;
    mw_t e;
    idx = int'(alu[AW:2]);
    hit = 1'b0;
    if (w) begin
      ref_mem[idx] = rm;
      e = '{wb_en: wb, mem_r_en: 1'b0, alu: alu, data: 32'd0, dest: d};
      exp_stall = FULL_STALL;
      bvalid = 1'b1;
      bidx   = idx;
    end else if (r) begin
      e = '{wb_en: wb, mem_r_en: 1'b1, alu: alu, data: ref_mem[idx], dest: d};
`ifdef MEM_READ_BYPASS_EN
      hit = bvalid && (bidx == idx);
`endif
      exp_stall = hit ? 0 : FULL_STALL;
      bvalid = 1'b1;
      bidx   = idx;
    end else begin
      e = '{wb_en: wb, mem_r_en: 1'b0, alu: alu, data: 32'd0, dest: d};
      exp_stall = 0;
    end
    wb_en_in      = wb;
    mem_r_en_in   = r;
    mem_w_en_in   = w;
    alu_result_in = alu;
    val_rm_in     = rm;
    dest_in       = d;
    exp_q.push_back(e);
    stalls = 0;
    forever begin
      @(negedge clk);
      if (ready) break;
      stalls++;
      if (stalls > 40) begin
        checkOutput("stall_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #2;
    checkOutput("stall_cycles", stalls, exp_stall);
  endtask

  function automatic logic [31:0] makeAddr(input int idx);
    return ($urandom & 32'hFFF8_0000) | (32'(idx) << 2) | ($urandom & 32'h3);
  endfunction

  // Abort a store on its second HI cycle and confirm a clean reset.
  task automatic resetMidAccess();
    int writes_before;
    wb_en_in      = 1'b0;
    mem_r_en_in   = 1'b0;
    mem_w_en_in   = 1'b1;
    alu_result_in = 32'd63 << 2;
    val_rm_in     = 32'hA5A5_5A5A;
    dest_in       = 4'd9;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("abort_we_low", {31'd0, sram.sram_we_n}, 32'd0);
    rst         = 1'b1;
    mem_w_en_in = 1'b0;
    alu_result_in = 32'd0;
    val_rm_in   = 32'd0;
    dest_in     = 4'd0;
    @(posedge clk);
    #2;
    checkOutput("abort_ready",    {31'd0, ready},            32'd1);
    checkOutput("abort_we_n",     {31'd0, sram.sram_we_n},   32'd1);
    checkOutput("abort_oe",       {31'd0, sram.sram_dq_oe},  32'd0);
    checkOutput("abort_addr",     32'(sram.sram_addr),       32'd0);
    checkOutput("abort_wb_en",    {31'd0, wb_en},            32'd0);
    checkOutput("abort_alu",      alu_result,                32'd0);
    checkOutput("abort_mem_data", mem_data,                  32'd0);
    checkOutput("abort_dest",     {28'd0, dest},             32'd0);
    writes_before = write_count;
    bvalid = 1'b0;
    rst    = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'd0, 4'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'd0, 4'd0);
    checkOutput("abort_no_writes", write_count, writes_before);
  endtask

  // Main sequence: reset checks, directed cases, random traffic, reset abort.
  initial begin
    int k, idx;
    logic [31:0] rm;
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
    alu_result_in = 0; val_rm_in = 0; dest_in = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
    bvalid = 1'b0;
    bidx   = 0;
    rst    = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_ready",    {31'd0, ready},           32'd1);
    checkOutput("rst_wb_en",    {31'd0, wb_en},           32'd0);
    checkOutput("rst_mem_r_en", {31'd0, mem_r_en},        32'd0);
    checkOutput("rst_alu",      alu_result,               32'd0);
    checkOutput("rst_mem_data", mem_data,                 32'd0);
    checkOutput("rst_dest",     {28'd0, dest},            32'd0);
    checkOutput("rst_we_n",     {31'd0, sram.sram_we_n},  32'd1);
    checkOutput("rst_oe",       {31'd0, sram.sram_dq_oe}, 32'd0);
    checkOutput("rst_addr",     32'(sram.sram_addr),      32'd0);
    checkOutput("rst_dq_out",   {16'd0, sram.sram_dq_out}, 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h55, 32'd0, 4'd3);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'd5);
    checkOutput("str_lo_half", {16'd0, sram_mem[8'h20]}, 32'h0000_BEEF);
    checkOutput("str_hi_half", {16'd0, sram_mem[8'h21]}, 32'h0000_DEAD);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h40, 32'd0, 4'd7);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h40, 32'd0, 4'd8);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, 32'h1234_5678, 4'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h40, 32'd0, 4'd4);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h84, 32'hCAFE_F00D, 4'd6);
    checkOutput("both_lo_half", {16'd0, sram_mem[8'h42]}, 32'h0000_F00D);
    checkOutput("both_hi_half", {16'd0, sram_mem[8'h43]}, 32'h0000_CAFE);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0087, 32'd0, 4'd11);

    for (int n = 0; n < 150; n++) begin
      k   = $urandom_range(0, 9);
      idx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 62);
      rm  = $urandom;
      if (k <= 2)      applyStimulus(1'($urandom), 1'b0, 1'b0, $urandom, rm, 4'($urandom));
      else if (k <= 5) applyStimulus(1'($urandom), 1'b0, 1'b1, makeAddr(idx), rm, 4'($urandom));
      else if (k <= 8) applyStimulus(1'b1, 1'b1, 1'b0, makeAddr(idx), rm, 4'($urandom));
      else             applyStimulus(1'($urandom), 1'b1, 1'b1, makeAddr(idx), rm, 4'($urandom));
    end

    resetMidAccess();

    for (int n = 0; n < 20; n++) begin
      idx = $urandom_range(0, 3);
      if (n % 3 == 0) applyStimulus(1'b0, 1'b0, 1'b1, makeAddr(idx), $urandom, 4'($urandom));
      else            applyStimulus(1'b1, 1'b1, 1'b0, makeAddr(idx), 32'd0, 4'($urandom));
    end

    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge clk);
    #2;
    checkOutput("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
